parking_sensor_gen: RTL and testbench

Car-passage stimulus generator for the parking subsystem. On command it drives the two-bit gate sensor bus `{a, b}` through the exact entry or exit frame that the parking entry/exit detector accepts, with programmable dwell per phase, an inter-frame gap and a repeat count. It sits on the sensor side of the detector: in the FPGA demo build it replaces the physical beam sensors, and in benches it is the standard stimulus source for the occupancy logic.

---
 rtl/parking_sensor_gen.sv | 154 +++++++++++++++
 tb/tb_parking_sensor_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_sensor_gen.sv
// parking_sensor_gen: drives the {a, b} gate sensor bus through entry/exit
// frames with programmable dwell per phase, an inter-frame gap and a repeat count.
module parking_sensor_gen #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned GAP   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    input  logic [3:0] reps,
    input  logic       abort,
    output logic [1:0] sensor,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_CNT = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        GAP_S = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [3:0]       frames, frames_nxt;
    logic             dir_q, dir_nxt;
    logic [1:0]       sensor_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             last_phase;

    // Sensor pattern for a given direction and phase index.
    function automatic logic [1:0] phase_value(input logic d, input logic [1:0] i);
        logic [1:0] v;
        v = 2'b00;
        if (d) begin
            case (i)
                2'd0:    v = 2'b10;
                2'd1:    v = 2'b11;
                2'd2:    v = 2'b01;
                default: v = 2'b00;
            endcase
        end else begin
            v = 2'b01;
        end
        return v;
    endfunction

    // State and counter registers; outputs registered from next-state values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            frames <= '0;
            dir_q  <= 1'b0;
            sensor <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            frames <= frames_nxt;
            dir_q  <= dir_nxt;
            sensor <= sensor_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        frames_nxt = frames;
        dir_nxt    = dir_q;
        sensor_nxt = 2'b00;
        busy_nxt   = 1'b1;
        done_nxt   = 1'b0;
        last_phase = dir_q ? (idx == 2'd2) : 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    dir_nxt    = dir;
                    frames_nxt = (reps == 4'd0) ? 4'd1 : reps;
                    idx_nxt    = 2'd0;
                    cnt_nxt    = '0;
                    state_nxt  = PHASE;
                end
            end
            PHASE: begin
                if (abort) begin
                    state_nxt  = GAP_S;
                    cnt_nxt    = '0;
                    frames_nxt = 4'd0;
                end else if (cnt == DWELL_LAST) begin
                    cnt_nxt = '0;
                    if (last_phase) begin
                        state_nxt = GAP_S;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP_S: begin
                if (abort) begin
                    cnt_nxt    = '0;
                    frames_nxt = 4'd0;
                end else if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (frames > 4'd1) begin
                        frames_nxt = frames - 4'd1;
                        idx_nxt    = 2'd0;
                        state_nxt  = PHASE;
                    end else if (frames == 4'd0) begin
                        // Aborted burst: back to idle without a done pulse.
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        case (state_nxt)
            IDLE:    busy_nxt   = 1'b0;
            PHASE:   sensor_nxt = phase_value(dir_nxt, idx_nxt);
            DONE:    done_nxt   = 1'b1;
            default: sensor_nxt = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Bench for parking_sensor_gen: per-cycle scoreboard of {sensor, busy, done}.
module tb_parking_sensor_gen;

    localparam int unsigned DWELL = 2;
    localparam int unsigned GAP   = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       dir;
    logic [3:0] reps;
    logic       abort;
    logic [1:0] sensor;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [1:0] sensor;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        bit       dir;
        bit [3:0] reps;
        int       exp_busy;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[6];
    int   n_cmp;
    int   n_err;
    int   busy_cnt;

    parking_sensor_gen #(.DWELL(DWELL), .GAP(GAP)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dir    (dir),
        .reps   (reps),
        .abort  (abort),
        .sensor (sensor),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_obs(input logic [1:0] s, input logic b, input logic d);
        obs_t o;
        o.sensor = s;
        o.busy   = b;
        o.done   = d;
        exp_q.push_back(o);
    endfunction

    // Reference burst: frames of phases x DWELL, GAP of 00, done cycle, one idle cycle.
    function automatic void push_burst(input bit d, input bit [3:0] r);
        int reff;
        reff = (r == 4'd0) ? 1 : int'(r);
        for (int f = 0; f < reff; f++) begin
            if (d) begin
                for (int k = 0; k < int'(DWELL); k++) push_obs(2'b10, 1'b1, 1'b0);
                for (int k = 0; k < int'(DWELL); k++) push_obs(2'b11, 1'b1, 1'b0);
                for (int k = 0; k < int'(DWELL); k++) push_obs(2'b01, 1'b1, 1'b0);
            end else begin
                for (int k = 0; k < int'(DWELL); k++) push_obs(2'b01, 1'b1, 1'b0);
            end
            for (int k = 0; k < int'(GAP); k++) push_obs(2'b00, 1'b1, 1'b0);
        end
        push_obs(2'b00, 1'b1, 1'b1);
        push_obs(2'b00, 1'b0, 1'b0);
    endfunction

    // One cycle: sample at negedge against the next expected entry.
    task automatic step(input bit hold);
        obs_t e;
        obs_t a;
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            abort = 1'b0;
        end
        a.sensor = sensor;
        a.busy   = busy;
        a.done   = done;
        if (busy === 1'b1) busy_cnt++;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("cycle_obs", int'(a), int'(e));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            step(1'b0);
            guard++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 0, 1);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        busy_cnt = 0;
        reset    = 1'b0;
        start    = 1'b1;
        dir      = 1'b1;
        reps     = 4'd2;
        abort    = 1'b0;

        vecs[0] = '{dir: 1'b1, reps: 4'd1, exp_busy: 10};
        vecs[1] = '{dir: 1'b0, reps: 4'd3, exp_busy: 16};
        vecs[2] = '{dir: 1'b1, reps: 4'd0, exp_busy: 10};
        vecs[3] = '{dir: 1'b1, reps: 4'd2, exp_busy: 19};
        vecs[4] = '{dir: 1'b0, reps: 4'd1, exp_busy: 6};
        vecs[5] = '{dir: 1'b0, reps: 4'd0, exp_busy: 6};

        // Reset held with start high: outputs stay idle, and one cycle after release.
        for (int i = 0; i < 3; i++) begin
            push_obs(2'b00, 1'b0, 1'b0);
            step(1'b1);
        end
        reset = 1'b1;
        start = 1'b0;
        push_obs(2'b00, 1'b0, 1'b0);
        step(1'b0);

        // Table-driven bursts.
        for (int i = 0; i < 6; i++) begin
            busy_cnt = 0;
            push_burst(vecs[i].dir, vecs[i].reps);
            start = 1'b1;
            dir   = vecs[i].dir;
            reps  = vecs[i].reps;
            drain();
            check($sformatf("busy_len_%0d", i), busy_cnt, vecs[i].exp_busy);
        end

        // Abort during phase 11 of an entry frame.
        busy_cnt = 0;
        push_obs(2'b10, 1'b1, 1'b0);
        push_obs(2'b10, 1'b1, 1'b0);
        push_obs(2'b11, 1'b1, 1'b0);
        start = 1'b1;
        dir   = 1'b1;
        reps  = 4'd2;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        abort = 1'b1;
        for (int k = 0; k < int'(GAP); k++) push_obs(2'b00, 1'b1, 1'b0);
        push_obs(2'b00, 1'b0, 1'b0);
        push_obs(2'b00, 1'b0, 1'b0);
        drain();
        check("abort_busy_len", busy_cnt, 3 + int'(GAP));

        // Start pulsed mid-burst with different dir/reps is ignored.
        busy_cnt = 0;
        push_burst(1'b0, 4'd2);
        start = 1'b1;
        dir   = 1'b0;
        reps  = 4'd2;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        start = 1'b1;
        dir   = 1'b1;
        reps  = 4'd4;
        drain();
        check("ignored_start_busy_len", busy_cnt, 11);

        // Start held across DONE -> IDLE: one idle cycle then the next burst.
        push_burst(1'b0, 4'd1);
        push_burst(1'b0, 4'd1);
        start = 1'b1;
        dir   = 1'b0;
        reps  = 4'd1;
        for (int k = 0; k < 7; k++) step(1'b1);
        drain();

        // Reset mid-GAP of frame 2 of 4.
        for (int k = 0; k < 2; k++) push_obs(2'b01, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) push_obs(2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) push_obs(2'b01, 1'b1, 1'b0);
        push_obs(2'b00, 1'b1, 1'b0);
        start = 1'b1;
        dir   = 1'b0;
        reps  = 4'd4;
        drain();
        reset = 1'b0;
        push_obs(2'b00, 1'b0, 1'b0);
        step(1'b0);
        reset = 1'b1;
        push_obs(2'b00, 1'b0, 1'b0);
        push_obs(2'b00, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
